seg_scan_capture: RTL

Display-side stage fed by the datapath. It samples the datapath's write-back data and PC result on each rising edge of the slow datapath clock and holds them in shadow registers. It time-multiplexes the held values as 8 hex digits on a common seven-segment display, so the display stays stable between datapath steps.

---
 rtl/seg_scan_if.sv | 20 ++
 rtl/seg_scan_capture.sv | 84 ++++++++
 2 files changed

// File: rtl/seg_scan_if.sv
// seg_scan_if: datapath-to-display bundle for seg_scan_capture
interface seg_scan_if;
    logic        Tick;
    logic [31:0] WriteData;
    logic [31:0] PCResult;
    logic        Freeze;
    logic [6:0]  out7;
    logic [7:0]  en_out;
    logic        Captured;

    modport master (
        output Tick, WriteData, PCResult, Freeze,
        input  out7, en_out, Captured
    );

    modport slave (
        input  Tick, WriteData, PCResult, Freeze,
        output out7, en_out, Captured
    );
endinterface

// File: rtl/seg_scan_capture.sv
// seg_scan_capture: capture datapath results on Tick rises and scan them as 8 hex digits
module seg_scan_capture #(
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = 17
) (
    input logic       Clk,
    input logic       Reset,
    seg_scan_if.slave bus
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [6:0] SEG [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic             s1_q, s1_d, s2_q, s2_d, d_q, d_d;
    logic             cap_q, cap_d, load;
    logic [15:0]      sh_wd_q, sh_wd_d, sh_pc_q, sh_pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic             wrap;
    logic [31:0]      cat;
    logic [3:0]       nib;
    logic [6:0]       out7_q, out7_d;
    logic [7:0]       en_out_q, en_out_d;
    logic             unused_hi;

    assign unused_hi = ^{bus.WriteData[31:16], bus.PCResult[31:16]};

    // Synchronise Tick, detect its rising edge and load the shadows unless frozen
    always_comb begin
        s1_d    = bus.Tick;
        s2_d    = s1_q;
        d_d     = s2_q;
        load    = s2_q & ~d_q & ~bus.Freeze;
        cap_d   = load;
        sh_wd_d = load ? bus.WriteData[15:0] : sh_wd_q;
        sh_pc_d = load ? bus.PCResult[15:0] : sh_pc_q;
    end

    // Dwell counter and digit scan; outputs are built from the pre-edge idx and shadows
    always_comb begin
        wrap     = cnt_q == LAST;
        cnt_d    = wrap ? '0 : cnt_q + CNT_W'(1);
        idx_d    = wrap ? idx_q + 3'd1 : idx_q;
        cat      = {sh_pc_q, sh_wd_q};
        nib      = cat[{idx_q, 2'b00} +: 4];
        out7_d   = SEG[nib];
        en_out_d = ~(8'b1 << idx_q);
    end

    // State register; reset blanks the display immediately
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            d_q      <= 1'b0;
            cap_q    <= 1'b0;
            sh_wd_q  <= '0;
            sh_pc_q  <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            out7_q   <= 7'h7F;
            en_out_q <= 8'hFF;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            d_q      <= d_d;
            cap_q    <= cap_d;
            sh_wd_q  <= sh_wd_d;
            sh_pc_q  <= sh_pc_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            out7_q   <= out7_d;
            en_out_q <= en_out_d;
        end
    end

    assign bus.out7     = out7_q;
    assign bus.en_out   = en_out_q;
    assign bus.Captured = cap_q;
endmodule
